// File: rtl/cpu_defs.sv
// Shared CPU-wide constants: exception codes, nop encoding and the fixed PC vectors
// used by the PC register, CP0 and the IF/ID register.
package cpu_defs;

  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO    = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI    = 32'h0000_6ffc;

endpackage

// File: rtl/if_id_reg_fetch_exc_check.sv
// Combinational word-address legality check: alignment plus an unsigned [LO, HI] window.
// EXC_CODE is a parameter so the data-address check in M can report AdES with the same logic.
module fetch_exc_check
  import cpu_defs::*;
#(
  parameter logic [31:0] ADDR_LO  = IMEM_LO,
  parameter logic [31:0] ADDR_HI  = IMEM_HI,
  parameter logic [4:0]  EXC_CODE = EXC_ADEL
) (
  input  logic [31:0] addr,
  output logic        bad,
  output logic [4:0]  code
);

  logic misaligned;
  logic below;
  logic above;

  // Unsigned compares, so addresses near 0xffff_fffc never wrap back into range.
  always_comb begin
    misaligned = (addr[1:0] != 2'b00);
    below      = (addr < ADDR_LO);
    above      = (addr > ADDR_HI);
    bad        = misaligned | below | above;
    if (bad) begin
      code = EXC_CODE;
    end else begin
      code = EXC_NONE;
    end
  end

endmodule

// File: rtl/if_id_reg.sv
// Fetch/decode pipeline register: captures PC and instruction, tags AdEL fetch faults and
// carries the branch-delay-slot flag that CP0 needs for EPC/Cause.BD.
module if_id_reg
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC_P   = RESET_PC,
  parameter logic [31:0] HANDLER_PC_P = HANDLER_PC,
  parameter logic [31:0] IMEM_LO_P    = IMEM_LO,
  parameter logic [31:0] IMEM_HI_P    = IMEM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic        kill,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  input  logic        bd_in,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        valid_d,
  output logic        has_exc_d,
  output logic [4:0]  exc_d,
  output logic        bd_d
);

  logic       fetch_bad;
  logic [4:0] fetch_code;

  fetch_exc_check #(
    .ADDR_LO  (IMEM_LO_P),
    .ADDR_HI  (IMEM_HI_P),
    .EXC_CODE (EXC_ADEL)
  ) u_fetch_exc_check (
    .addr (pc_f),
    .bad  (fetch_bad),
    .code (fetch_code)
  );

  // Power-up contents equal the reset bubble so D is sane before the first reset edge.
  logic [31:0] pc_q      = RESET_PC_P;
  logic [31:0] instr_q   = NOP_WORD;
  logic        valid_q   = 1'b0;
  logic        has_exc_q = 1'b0;
  logic [4:0]  exc_q     = EXC_NONE;
  logic        bd_q      = 1'b0;

  // Priority: reset > flush > hold > kill > load. Flush overrides a stall; kill during a stall is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC_P;
      instr_q   <= NOP_WORD;
      valid_q   <= 1'b0;
      has_exc_q <= 1'b0;
      exc_q     <= EXC_NONE;
      bd_q      <= 1'b0;
    end else if (flush) begin
      pc_q      <= HANDLER_PC_P;
      instr_q   <= NOP_WORD;
      valid_q   <= 1'b0;
      has_exc_q <= 1'b0;
      exc_q     <= EXC_NONE;
      bd_q      <= 1'b0;
    end else if (!en) begin
      pc_q      <= pc_q;
      instr_q   <= instr_q;
      valid_q   <= valid_q;
      has_exc_q <= has_exc_q;
      exc_q     <= exc_q;
      bd_q      <= bd_q;
    end else if (kill) begin
      // PC kept on the bubble so an interrupt landing here still gets a correct EPC.
      pc_q      <= pc_f;
      instr_q   <= NOP_WORD;
      valid_q   <= 1'b0;
      has_exc_q <= 1'b0;
      exc_q     <= EXC_NONE;
      bd_q      <= bd_in;
    end else begin
      pc_q      <= pc_f;
      instr_q   <= fetch_bad ? NOP_WORD : instr_f;
      valid_q   <= 1'b1;
      has_exc_q <= fetch_bad;
      exc_q     <= fetch_code;
      bd_q      <= bd_in;
    end
  end

  assign pc_d      = pc_q;
  assign instr_d   = instr_q;
  assign valid_d   = valid_q;
  assign has_exc_d = has_exc_q;
  assign exc_d     = exc_q;
  assign bd_d      = bd_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboard bench for if_id_reg: each driven cycle pushes the expected D entry,
// which is popped and compared one edge later.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        reset, en, flush, kill, bd_in;
  logic [31:0] pc_f, instr_f;
  logic [31:0] pc_d, instr_d;
  logic        valid_d, has_exc_d, bd_d;
  logic [4:0]  exc_d;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        has_exc;
    logic [4:0]  exc;
    logic        bd;
  } entry_t;

  entry_t model;
  entry_t exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  if_id_reg dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .kill      (kill),
    .pc_f      (pc_f),
    .instr_f   (instr_f),
    .bd_in     (bd_in),
    .pc_d      (pc_d),
    .instr_d   (instr_d),
    .valid_d   (valid_d),
    .has_exc_d (has_exc_d),
    .exc_d     (exc_d),
    .bd_d      (bd_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6ffc);
  endfunction

  task automatic compare_entry(input string tag);
    entry_t e;
    if (exp_q.size() == 0) begin
      check({tag, ".queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".pc_d"},      pc_d,             e.pc);
      check({tag, ".instr_d"},   instr_d,          e.instr);
      check({tag, ".valid_d"},   32'(valid_d),     32'(e.valid));
      check({tag, ".has_exc_d"}, 32'(has_exc_d),   32'(e.has_exc));
      check({tag, ".exc_d"},     32'(exc_d),       32'(e.exc));
      check({tag, ".bd_d"},      32'(bd_d),        32'(e.bd));
    end
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic f,
                      input logic k, input logic [31:0] pc, input logic [31:0] ins,
                      input logic bd);
    @(negedge clk);
    reset = r; en = e; flush = f; kill = k; pc_f = pc; instr_f = ins; bd_in = bd;
    if (r || f) begin
      model.pc = r ? 32'h0000_3000 : 32'h0000_4180;
      model.instr = 32'h0; model.valid = 1'b0; model.has_exc = 1'b0;
      model.exc = 5'd0; model.bd = 1'b0;
    end else if (!e) begin
      model = model;
    end else if (k) begin
      model.pc = pc; model.instr = 32'h0; model.valid = 1'b0;
      model.has_exc = 1'b0; model.exc = 5'd0; model.bd = bd;
    end else begin
      model.pc = pc; model.valid = 1'b1; model.bd = bd;
      model.has_exc = addr_bad(pc);
      model.exc = addr_bad(pc) ? 5'd4 : 5'd0;
      model.instr = addr_bad(pc) ? 32'h0 : ins;
    end
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    compare_entry(tag);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; flush = 1'b0; kill = 1'b0;
    pc_f = 32'h0; instr_f = 32'h0; bd_in = 1'b0;
    model = '{32'h0000_3000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0};
    #1;
    exp_q.push_back(model);
    compare_entry("powerup");

    step("reset0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h3010, 32'h1234_5678, 1'b1);
    step("reset1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h3010, 32'h1234_5678, 1'b1);
    step("load",   1'b0, 1'b1, 1'b0, 1'b0, 32'h3004, 32'h2408_0001, 1'b1);
    for (int i = 0; i < 3; i++)
      step("stall", 1'b0, 1'b0, 1'b0, 1'b0, 32'h3008, 32'hdead_beef, 1'b0);
    step("misalign", 1'b0, 1'b1, 1'b0, 1'b0, 32'h3002, 32'hffff_ffff, 1'b0);
    step("over_hi",  1'b0, 1'b1, 1'b0, 1'b0, 32'h7000, 32'h1111_1111, 1'b0);
    step("at_hi",    1'b0, 1'b1, 1'b0, 1'b0, 32'h6ffc, 32'h2222_2222, 1'b1);
    step("below_lo", 1'b0, 1'b1, 1'b0, 1'b0, 32'h2ffc, 32'h3333_3333, 1'b0);
    step("at_lo",    1'b0, 1'b1, 1'b0, 1'b0, 32'h3000, 32'h4444_4444, 1'b0);
    step("top_addr", 1'b0, 1'b1, 1'b0, 1'b0, 32'hffff_fffc, 32'h5555_5555, 1'b1);
    step("flush_pri",1'b0, 1'b0, 1'b1, 1'b1, 32'h3020, 32'h6666_6666, 1'b1);
    step("flush_b2b",1'b0, 1'b1, 1'b1, 1'b0, 32'h3024, 32'h7777_7777, 1'b1);
    step("kill",     1'b0, 1'b1, 1'b0, 1'b1, 32'h3040, 32'h8c09_0000, 1'b1);
    step("load2",    1'b0, 1'b1, 1'b0, 1'b0, 32'h3044, 32'h0109_5020, 1'b0);
    step("kill_stall",1'b0,1'b0, 1'b0, 1'b1, 32'h3048, 32'h9999_9999, 1'b1);
    step("kill_stall2",1'b0,1'b0,1'b0, 1'b1, 32'h3048, 32'h9999_9999, 1'b1);
    step("after_stall",1'b0,1'b1,1'b0, 1'b0, 32'h3048, 32'h0000_000c, 1'b0);
    step("pre_rst",  1'b0, 1'b1, 1'b0, 1'b0, 32'h304c, 32'habcd_0001, 1'b1);
    step("rst_stall",1'b1, 1'b0, 1'b1, 1'b1, 32'h3050, 32'habcd_0002, 1'b1);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      a = 32'h2ff0 + 32'($urandom_range(0, 16'h4020));
      step("rand", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 4) == 0), a, $urandom, 1'($urandom_range(0, 1)));
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
